// File: rtl/counter_arbiter_if.sv
// Requester-side bundle of the counter_arbiter: requests and run lengths in,
// grant/owner/enable/status out.
interface counter_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 3
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] len;
   logic [NUM_REQ-1:0]       grant;
   logic [IDW-1:0]           owner_id;
   logic                     enable;
   logic                     busy;
   logic [NUM_REQ-1:0]       done;

   modport master (
      output req, len,
      input  grant, owner_id, enable, busy, done
   );

   modport slave (
      input  req, len,
      output grant, owner_id, enable, busy, done
   );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin owner selection for one shared counter: the owner gets exactly
// len enabled cycles, then a one-cycle done pulse, then an idle cycle.
module counter_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 3
) (
   input logic              clk,
   input logic              rst,
   counter_arbiter_if.slave bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [IDW-1:0]       ptr;
   logic [WIDTH-1:0]     remaining;

   logic                 found;
   logic [IDW-1:0]       win;
   logic [WIDTH-1:0]     win_len;
   logic [NUM_REQ-1:0]   win_onehot;
   logic [IDW-1:0]       next_ptr;
   int unsigned          idx;

   // first requester at or after ptr, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   assign win_len    = bus.len[win*WIDTH +: WIDTH];
   assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
   assign next_ptr   = (bus.owner_id == IDW'(NUM_REQ-1)) ? '0 : bus.owner_id + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         remaining    <= '0;
         bus.grant    <= '0;
         bus.owner_id <= '0;
         bus.enable   <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= '0;
      end else begin
         bus.done <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  bus.grant    <= win_onehot;
                  bus.owner_id <= win;
                  bus.busy     <= 1'b1;
                  remaining    <= win_len;
                  if (win_len != '0) begin
                     state      <= RUN;
                     bus.enable <= 1'b1;
                  end else begin
                     state      <= DONE;
                     bus.enable <= 1'b0;
                     bus.done   <= win_onehot;
                  end
               end
            end
            RUN: begin
               // an owner dropping req aborts even on what would be the final cycle
               if (!bus.req[bus.owner_id]) begin
                  state        <= IDLE;
                  bus.grant    <= '0;
                  bus.owner_id <= '0;
                  bus.busy     <= 1'b0;
                  bus.enable   <= 1'b0;
                  remaining    <= '0;
                  ptr          <= next_ptr;
               end else if (remaining == WIDTH'(1)) begin
                  state      <= DONE;
                  bus.enable <= 1'b0;
                  bus.done   <= bus.grant;
                  remaining  <= '0;
               end else begin
                  remaining <= remaining - 1'b1;
               end
            end
            DONE: begin
               state        <= IDLE;
               bus.grant    <= '0;
               bus.owner_id <= '0;
               bus.busy     <= 1'b0;
               ptr          <= next_ptr;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of owner, remaining run and pointer.
module tb_counter_arbiter;
   localparam int N = 4;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   counter_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // the shared counter datapath driven by the arbiter
   logic [W-1:0] count;
   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else if (bus.enable) count <= count + 1'b1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference: who owns the counter, how many enabled cycles are left,
   // whether this is the done cycle, and where the next scan starts
   int m_owner = -1;
   int m_left  = 0;
   bit m_done  = 1'b0;
   int m_ptr   = 0;
   int m_runlen = 0;
   int m_cnt   = 0;

   function automatic int len_of(int i);
      return int'(bus.len[i*W +: W]);
   endfunction

   function automatic int m_grant();
      return (m_owner < 0) ? 0 : (1 << m_owner);
   endfunction

   function automatic bit m_enable();
      return (m_owner >= 0) && !m_done && (m_left > 0);
   endfunction

   task automatic model_step();
      if (rst) begin
         m_owner = -1; m_left = 0; m_done = 1'b0; m_ptr = 0; m_cnt = 0;
         return;
      end
      if (m_enable()) m_cnt = (m_cnt + 1) % (1 << W);
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (bus.req[c]) begin
               m_owner  = c;
               m_left   = len_of(c);
               m_runlen = m_left;
               m_done   = (m_left == 0);
               break;
            end
         end
      end else if (m_done) begin
         m_ptr = (m_owner + 1) % N;
         m_owner = -1;
         m_done = 1'b0;
      end else if (!bus.req[m_owner]) begin
         m_ptr = (m_owner + 1) % N;
         m_owner = -1;
         m_left = 0;
      end else begin
         m_left--;
         m_done = (m_left == 0);
      end
   endtask

   logic [N-1:0] prev_grant = '0;
   logic [W-1:0] run_start  = '0;
   logic [W-1:0] delta;
   int wait_cnt [N];

   task automatic compare_all();
      int w;
      check("grant",    bus.grant,    m_grant());
      check("owner_id", bus.owner_id, (m_owner < 0) ? 0 : m_owner);
      check("enable",   bus.enable,   m_enable());
      check("busy",     bus.busy,     m_owner >= 0);
      check("done",     bus.done,     m_done ? m_grant() : 0);
      check("count",    count,        m_cnt);
      check("inv_onehot", $onehot0(bus.grant), 1);
      check("inv_enable", !bus.enable || $onehot(bus.grant), 1);
      check("inv_done",   (bus.done & ~bus.grant) == '0, 1);

      for (int j = 0; j < N; j++)
         if (rst || !bus.req[j]) wait_cnt[j] = 0;
      if (prev_grant == '0 && bus.grant != '0) begin
         w = 0;
         for (int j = 0; j < N; j++) if (bus.grant[j]) w = j;
         check("fairness", wait_cnt[w] <= N - 1, 1);
         run_start = count;
         for (int j = 0; j < N; j++)
            if (j != w && bus.req[j]) wait_cnt[j]++;
         wait_cnt[w] = 0;
      end
      if (bus.done != '0) begin
         delta = count - run_start;
         check("run_delta", delta, m_runlen);
      end
      prev_grant = bus.grant;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int en;
   int order [$];
   logic [N-1:0] lg;

   initial begin
      for (int j = 0; j < N; j++) wait_cnt[j] = 0;
      rst = 1'b1;
      bus.req = '0;
      bus.len = '0;
      tick();
      tick();
      check("rst_grant", bus.grant, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_enable", bus.enable, 0);
      rst = 1'b0;

      // single requester, len 3
      bus.len = {3'd0, 3'd0, 3'd0, 3'd3};
      bus.req = 4'b0001;
      tick();
      check("t1_grant", bus.grant, 4'b0001);
      en = bus.enable;
      for (int c = 0; c < 10 && bus.done == '0; c++) begin
         tick();
         en += bus.enable;
      end
      check("t1_en_cycles", en, 3);
      check("t1_done", bus.done, 4'b0001);
      bus.req = '0;
      tick();
      check("t1_busy", bus.busy, 0);
      check("t1_count", count, 3);

      // all request, len 2 each: strict rotation 0,1,2,3,0
      do_reset();
      bus.len = {4{3'd2}};
      bus.req = 4'b1111;
      order.delete();
      for (int c = 0; c < 80 && order.size() < 5; c++) begin
         lg = bus.grant;
         tick();
         if (lg == '0 && bus.grant != '0) order.push_back(int'(bus.owner_id));
      end
      check("t2_grants", order.size(), 5);
      for (int k = 0; k < order.size(); k++) check("t2_order", order[k], k % N);
      bus.req = '0;
      for (int c = 0; c < 10 && bus.busy; c++) tick();

      // zero-length run
      do_reset();
      bus.len = '0;
      bus.req = 4'b0010;
      tick();
      check("t3_grant", bus.grant, 4'b0010);
      check("t3_enable", bus.enable, 0);
      check("t3_done", bus.done, 4'b0010);
      bus.req = '0;
      tick();
      check("t3_grant_off", bus.grant, 0);
      check("t3_count", count, 0);

      // abort after 3 enabled cycles, then requester 3 is served normally
      do_reset();
      bus.len = {3'd1, 3'd7, 3'd0, 3'd0};
      bus.req = 4'b0100;
      tick(); tick(); tick();
      check("t4_enable", bus.enable, 1);
      bus.req = '0;
      tick();
      check("t4_enable_off", bus.enable, 0);
      check("t4_no_done", bus.done, 0);
      check("t4_count", count, 3);
      bus.req = 4'b1000;
      tick();
      check("t4_grant3", bus.grant, 4'b1000);
      tick();
      check("t4_done3", bus.done, 4'b1000);
      bus.req = '0;
      tick();

      // reset mid-run restarts the pointer at 0
      do_reset();
      bus.len = {3'd0, 3'd0, 3'd5, 3'd1};
      bus.req = 4'b0001;
      tick(); tick();
      bus.req = '0;
      tick();
      bus.req = 4'b0010;
      tick(); tick();
      check("t5_enable", bus.enable, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_grant", bus.grant, 0);
      check("t5_enable_off", bus.enable, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_done", bus.done, 0);
      bus.req = 4'b0011;
      tick();
      check("t5_ptr0", bus.grant, 4'b0001);
      bus.req = '0;
      for (int c = 0; c < 10 && bus.busy; c++) tick();

      // random traffic
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         rst = ($urandom_range(499) == 0);
         for (int i = 0; i < N; i++) begin
            if (!bus.req[i]) begin
               if ($urandom_range(3) == 0) begin
                  bus.req[i] = 1'b1;
                  bus.len[i*W +: W] = W'($urandom_range(7));
               end
            end else if (bus.done[i]) begin
               bus.req[i] = 1'b0;
            end else if (bus.grant[i] && bus.enable && $urandom_range(31) == 0) begin
               bus.req[i] = 1'b0;
            end else if ($urandom_range(7) == 0) begin
               bus.len[i*W +: W] = W'($urandom_range(7));
            end
         end
         tick();
      end
      rst = 1'b0;
      bus.req = '0;
      tick(); tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
